// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bundle between the fetch sequencer and the memory.
// One request is outstanding at a time; data returns on rvalid at least one cycle after gnt.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the fetch PC, runs the imem req/gnt/rvalid handshake,
// squashes responses made stale by redirects, and loads the IF/ID register.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCSrcE,
  input  logic [31:0]         PCTargetE,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  fetch_sequencer_if.master   imem,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCD,
  output logic [31:0]         PCPlus4D,
  output logic                ValidD,
  output logic                fetch_busy,
  output logic [CNT_W-1:0]    fetch_stall_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_f, pc_f_nxt;
  logic [31:0] pc_req;
  logic        squash, squash_nxt;
  logic [31:0] hold_instr, hold_pc;

  logic        req;
  logic        fire;
  logic        take_new;
  logic        load_hold_buf;
  logic        bubble_wait;
  logic [31:0] new_instr, new_pc;

  logic [31:0]      instr_p1, pc_p1, pc4_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc_f   <= RESET_PC;
      squash <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_f   <= pc_f_nxt;
      squash <= squash_nxt;
    end
  end

  // take_new flags an instruction offered to decode; StallD/FlushD arbitrate it in the IF/ID stage
  always_comb begin
    state_nxt     = state;
    pc_f_nxt      = pc_f;
    squash_nxt    = squash;
    req           = 1'b0;
    fire          = 1'b0;
    take_new      = 1'b0;
    load_hold_buf = 1'b0;
    new_instr     = hold_instr;
    new_pc        = hold_pc;
    case (state)
      S_REQ: begin
        req  = !StallF;
        fire = req && imem.imem_gnt;
        if (fire) begin
          state_nxt  = S_WAIT;
          squash_nxt = PCSrcE;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          squash_nxt = 1'b0;
          if (squash || PCSrcE) begin
            state_nxt = S_REQ;
          end else begin
            pc_f_nxt  = pc_req + 32'd4;
            new_instr = imem.imem_rdata;
            new_pc    = pc_req;
            take_new  = 1'b1;
            if (StallD && !FlushD) begin
              state_nxt     = S_HOLD;
              load_hold_buf = 1'b1;
            end else begin
              state_nxt = S_REQ;
            end
          end
        end else if (PCSrcE) begin
          squash_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE || FlushD) begin
          state_nxt = S_REQ;
        end else if (!StallD) begin
          take_new  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    if (PCSrcE) pc_f_nxt = PCTargetE;
  end

  always_ff @(posedge clk) begin
    if (fire) pc_req <= pc_f;
    if (load_hold_buf) begin
      hold_instr <= imem.imem_rdata;
      hold_pc    <= pc_req;
    end
  end

  assign bubble_wait = (state == S_WAIT) && !FlushD && !StallD && !take_new;

  // ---- IF/ID stage boundary ----
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= 32'd0;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (!StallD) begin
      if (take_new) begin
        instr_p1 <= new_instr;
        pc_p1    <= new_pc;
        pc4_p1   <= new_pc + 32'd4;
        vld_p1   <= 1'b1;
      end else begin
        instr_p1 <= NOP_INSTR;
        pc_p1    <= 32'd0;
        pc4_p1   <= 32'd0;
        vld_p1   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (bubble_wait) stall_cnt <= sat_inc(stall_cnt);
  end

  assign imem.imem_req   = req;
  assign imem.imem_addr  = pc_f;
  assign InstrD          = instr_p1;
  assign PCD             = pc_p1;
  assign PCPlus4D        = pc4_p1;
  assign ValidD          = vld_p1;
  assign fetch_busy      = (state != S_REQ);
  assign fetch_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a transaction-level model predicts each cycle's
// outputs into a scoreboard queue, and a negedge monitor pops and compares.
module tb_fetch_sequencer;
  localparam int CW   = 3;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          PCSrcE = 1'b0;
  logic [31:0]   PCTargetE = 32'd0;
  logic          StallF = 1'b0;
  logic          StallD = 1'b0;
  logic          FlushD = 1'b0;
  logic [31:0]   InstrD, PCD, PCPlus4D;
  logic          ValidD, fetch_busy;
  logic [CW-1:0] fetch_stall_cnt;

  fetch_sequencer_if imem();

  fetch_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .imem(imem),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .fetch_busy(fetch_busy), .fetch_stall_cnt(fetch_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr, pc, pc4;
    logic        valid, busy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: fetch PC, at most one outstanding request, at most one parked word.
  bit            m_init = 0;
  logic [31:0]   m_pc;
  bit            m_out, m_out_stale, m_held;
  logic [31:0]   m_out_pc, m_held_instr, m_held_pc;
  logic [31:0]   m_instr, m_pcd, m_pc4;
  logic          m_valid;
  logic [CW-1:0] m_cnt;

  task automatic model_step();
    exp_t        e;
    bit          busy, mreq, resp, deliver, offered;
    logic [31:0] old_pc, off_instr, off_pc;
    busy = m_out || m_held;
    mreq = !busy && !StallF;
    e.chk = m_init;
    e.req = mreq; e.addr = m_pc; e.instr = m_instr; e.pc = m_pcd; e.pc4 = m_pc4;
    e.valid = m_valid; e.busy = busy; e.cnt = m_cnt;
    sb.push_back(e);
    if (rst) begin
      m_init = 1; m_pc = 32'h0; m_out = 0; m_out_stale = 0; m_held = 0;
      m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_cnt = '0;
    end else if (m_init) begin
      old_pc  = m_pc;
      resp    = m_out && imem.imem_rvalid;
      deliver = resp && !m_out_stale && !PCSrcE;
      offered = deliver || (m_held && !PCSrcE && !FlushD);
      off_instr = deliver ? mem_word(m_out_pc) : m_held_instr;
      off_pc    = deliver ? m_out_pc : m_held_pc;
      if (FlushD) begin
        m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 0;
      end else if (!StallD) begin
        if (offered) begin
          m_instr = off_instr; m_pcd = off_pc; m_pc4 = off_pc + 32'd4; m_valid = 1;
        end else begin
          m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 0;
          if (m_out && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
      end
      if (PCSrcE) m_pc = PCTargetE;
      else if (resp && !m_out_stale) m_pc = m_out_pc + 32'd4;
      if (m_held && (PCSrcE || FlushD || !StallD)) m_held = 0;
      if (deliver && StallD && !FlushD) begin
        m_held = 1; m_held_instr = off_instr; m_held_pc = off_pc;
      end
      if (m_out) begin
        if (imem.imem_rvalid) m_out = 0;
        else if (PCSrcE) m_out_stale = 1;
      end else if (mreq && imem.imem_gnt) begin
        m_out = 1; m_out_pc = old_pc; m_out_stale = PCSrcE;
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF8 + (32'($urandom_range(0, 1)) << 2);
    else t = 32'($urandom_range(0, 255)) << 2;
    return t;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          chk("imem_req", 32'(imem.imem_req), 32'(e.req));
          chk("imem_addr", imem.imem_addr, e.addr);
          chk("InstrD", InstrD, e.instr);
          chk("PCD", PCD, e.pc);
          chk("PCPlus4D", PCPlus4D, e.pc4);
          chk("ValidD", 32'(ValidD), 32'(e.valid));
          chk("fetch_busy", 32'(fetch_busy), 32'(e.busy));
          chk("fetch_stall_cnt", 32'(fetch_stall_cnt), 32'(e.cnt));
        end
      end
    end
  end

  // Driver + memory responder
  initial begin
    bit          pend = 0, had_pend, directed;
    int          pend_cnt = 0, lat;
    logic [31:0] pend_addr = 32'h0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      directed = (cyc < 50);
      if (cyc < 2) rst = 1'b1;
      else if (cyc >= 60 && $urandom_range(0, 399) == 0) rst = 1'b1;
      else rst = 1'b0;
      StallF    = directed ? 1'b0 : ($urandom_range(0, 9) < 2);
      StallD    = directed ? 1'b0 : ($urandom_range(0, 3) == 0);
      FlushD    = directed ? 1'b0 : ($urandom_range(0, 99) < 8);
      PCSrcE    = directed ? 1'b0 : ($urandom_range(0, 99) < 8);
      PCTargetE = pick_target();
      if (cyc < 20) lat = 0;
      else if (cyc < 50) lat = 3;
      else lat = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 4));
      had_pend = pend;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = $urandom;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = mem_word(pend_addr);
          pend = 0;
        end else begin
          pend_cnt--;
        end
      end else if (!directed && !m_out && $urandom_range(0, 19) == 0) begin
        imem.imem_rvalid = 1'b1;
      end
      imem.imem_gnt = !rst && !had_pend && (directed || ($urandom_range(0, 9) < 7));
      #1;
      if (imem.imem_req && imem.imem_gnt) begin
        pend = 1; pend_cnt = lat; pend_addr = imem.imem_addr;
      end
      model_step();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
